// File: rtl/mant_sub_pkg.sv
// Shared types and sizing helpers for the sequential mantissa subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mant_sub_pkg;

  // Controller states; NEG is only entered when MANT_SUB_ABS_EN is defined
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 26;
  localparam int DEF_CHUNK = 8;

  // Number of CHUNK-bit slices needed to cover WIDTH bits
  function automatic int nch(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/mant_sub_seq_chunk_rca.sv
// One CHUNK-bit ripple-carry adder slice with carry in and carry out.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module chunk_rca #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] sum;

  // Extend by one bit so the carry out falls into the top position
  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  end

  assign s    = sum[CHUNK-1:0];
  assign cout = sum[CHUNK];

endmodule

// File: rtl/mant_sub_seq.sv
// Sequential A - B over WIDTH bits, one CHUNK-bit slice per clock (optional |A-B| via MANT_SUB_ABS_EN).
// Latency: out_valid rises NCH clocks after accept (2*NCH when MANT_SUB_ABS_EN and A < B).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no accept/complete bypass.
module mant_sub_seq
  import mant_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy
);

  localparam int NCH = nch(WIDTH, CHUNK);
  localparam int PW  = NCH * CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  state_t                       state;
  logic [NCH-1:0][CHUNK-1:0]    op_a;
  logic [NCH-1:0][CHUNK-1:0]    op_nb;
  logic [NCH-1:0][CHUNK-1:0]    res;
  logic [PW-1:0]                res_flat;
  logic                         carry;
  logic [CW-1:0]                cnt;
  logic                         borrow_q;

  logic [CHUNK-1:0]             rca_a;
  logic [CHUNK-1:0]             rca_b;
  logic [CHUNK-1:0]             rca_s;
  logic                         rca_c;

  // Shared slice operands: minuend + inverted subtrahend in RUN, ~result + 0 in NEG
  always_comb begin
    rca_a = op_a[cnt];
    rca_b = op_nb[cnt];
    if (state == NEG) begin
      rca_a = ~res[cnt];
      rca_b = '0;
    end
  end

  chunk_rca #(
    .CHUNK (CHUNK)
  ) u_rca (
    .a    (rca_a),
    .b    (rca_b),
    .cin  (carry),
    .s    (rca_s),
    .cout (rca_c)
  );

  // Controller: accept, walk the chunks, optionally negate, then hold until taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      op_a      <= '0;
      op_nb     <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      borrow_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            // Padding of ~b is all ones so the last carry matches bit WIDTH-1's carry
            op_a     <= PW'(a);
            op_nb    <= ~(PW'(b));
            carry    <= 1'b1;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          res[cnt] <= rca_s;
          carry    <= rca_c;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) begin
            // No carry out of the top means the subtraction borrowed
            borrow_q <= ~rca_c;
            cnt      <= '0;
            carry    <= 1'b1;
`ifdef MANT_SUB_ABS_EN
            if (!rca_c) begin
              state <= NEG;
            end else begin
              busy      <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end
`else
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
`endif
          end
        end
        NEG: begin
          res[cnt] <= rca_s;
          carry    <= rca_c;
          cnt      <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign res_flat = res;
  assign diff     = res_flat[WIDTH-1:0];
  assign borrow   = borrow_q;

  // Padding bits above WIDTH never reach the result port
  generate
    if (PW > WIDTH) begin : g_pad
      logic pad_unused;
      assign pad_unused = ^res_flat[PW-1:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_mant_sub_seq.sv
// Self-checking bench for mant_sub_seq: vector table, handshake/reset corner cases, random back-to-back.
// Latency: checked against NCH (or 2*NCH with MANT_SUB_ABS_EN and A < B).
// Backpressure: exercised by holding out_ready low and by a continuous in_valid stream.
module tb_mant_sub_seq;

  localparam int W   = 26;
  localparam int NCH = 4;
  localparam int NOPS = 40;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         busy;

  int checks;
  int errors;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         br;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    int           lat;
    int           acc;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  mant_sub_seq #(
    .WIDTH (26),
    .CHUNK (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: unsigned difference from plain arithmetic on the operands
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t m;
    m.br  = (x < y);
    m.acc = 0;
`ifdef MANT_SUB_ABS_EN
    m.d   = m.br ? (y - x) : (x - y);
    m.lat = m.br ? 2 * NCH : NCH;
`else
    m.d   = x - y;
    m.lat = NCH;
`endif
    return m;
  endfunction

  // Present operands, wait for in_ready, complete the accepting edge
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
    int n;
    n = 0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count clocks from the accepting edge until out_valid is seen
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int   lat;
    int   cyc;
    int   got;
    int   sent;
    int   prev_res;
    bit   acc;
    exp_t e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    // Directed vectors: {a, b, diff, borrow, latency}
    vecs[0] = '{26'h0000005, 26'h0000003, 26'h0000002, 1'b0, NCH};
    vecs[1] = '{26'h3FFFFFF, 26'h3FFFFFF, 26'h0000000, 1'b0, NCH};
    vecs[2] = '{26'h0000100, 26'h0000001, 26'h00000FF, 1'b0, NCH};
    vecs[3] = '{26'h0000000, 26'h0000000, 26'h0000000, 1'b0, NCH};
    vecs[4] = '{26'h3FFFFFF, 26'h0000000, 26'h3FFFFFF, 1'b0, NCH};
    vecs[5] = '{26'h1000000, 26'h0FFFFFF, 26'h0000001, 1'b0, NCH};
`ifdef MANT_SUB_ABS_EN
    vecs[6] = '{26'h0000003, 26'h0000005, 26'h0000002, 1'b1, 2 * NCH};
    vecs[7] = '{26'h0000000, 26'h0000001, 26'h0000001, 1'b1, 2 * NCH};
    vecs[8] = '{26'h0000000, 26'h3FFFFFF, 26'h3FFFFFF, 1'b1, 2 * NCH};
`else
    vecs[6] = '{26'h0000003, 26'h0000005, 26'h3FFFFFE, 1'b1, NCH};
    vecs[7] = '{26'h0000000, 26'h0000001, 26'h3FFFFFF, 1'b1, NCH};
    vecs[8] = '{26'h0000000, 26'h3FFFFFF, 26'h0000001, 1'b1, NCH};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_diff",      {6'd0, diff},       32'd0);
    chk("rst_borrow",    {31'd0, borrow},    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven directed operations
    for (int i = 0; i < 9; i++) begin
      send(vecs[i].a, vecs[i].b);
      chk("vec_busy", {31'd0, busy}, 32'd1);
      wait_valid(lat);
      chk("vec_diff",    {6'd0, diff},     {6'd0, vecs[i].d});
      chk("vec_borrow",  {31'd0, borrow},  {31'd0, vecs[i].br});
      chk("vec_latency", lat,              vecs[i].lat);
      take();
      chk("vec_in_ready_after", {31'd0, in_ready},  32'd1);
      chk("vec_valid_dropped",  {31'd0, out_valid}, 32'd0);
    end

    // Result held under backpressure; stray in_valid must be ignored
    send(26'd20, 26'd7);
    wait_valid(lat);
    for (int k = 0; k < 5; k++) begin
      chk("hold_diff",     {6'd0, diff},      32'd13);
      chk("hold_borrow",   {31'd0, borrow},   32'd0);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_valid",    {31'd0, out_valid}, 32'd1);
      if (k == 1) begin
        a = 26'd99;
        b = 26'd1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    take();
    chk("hs_in_ready",  {31'd0, in_ready},  32'd1);
    chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hs_busy",      {31'd0, busy},      32'd0);
    chk("hs_diff_kept", {6'd0, diff},       32'd13);
    @(posedge clk); #1;
    chk("hs_no_stray_op", {31'd0, busy}, 32'd0);

    // Reset during the second RUN cycle aborts the operation
    send(26'd50, 26'd9);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready",  {31'd0, in_ready},  32'd1);
    chk("abort_busy",      {31'd0, busy},      32'd0);
    chk("abort_diff",      {6'd0, diff},       32'd0);
    chk("abort_borrow",    {31'd0, borrow},    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(26'd10, 26'd4);
    wait_valid(lat);
    chk("post_rst_diff",    {6'd0, diff},    32'd6);
    chk("post_rst_borrow",  {31'd0, borrow}, 32'd0);
    chk("post_rst_latency", lat,             NCH);
    take();

    // Random back-to-back stream with in_valid held high and out_ready held high
    out_ready = 1'b1;
    ra = W'($urandom);
    rb = W'($urandom);
    a = ra;
    b = rb;
    in_valid = 1'b1;
    sent = 0;
    got = 0;
    cyc = 0;
    prev_res = -1;
    while (got < NOPS && cyc < 3000) begin
      acc = in_valid && in_ready;
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("b2b_spurious", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("b2b_diff",    {6'd0, diff},    {6'd0, e.d});
          chk("b2b_borrow",  {31'd0, borrow}, {31'd0, e.br});
          chk("b2b_latency", cyc - e.acc,     e.lat);
          if (prev_res >= 0) chk("b2b_spacing", cyc - prev_res, e.lat + 2);
          prev_res = cyc;
          got++;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        e = model(a, b);
        e.acc = cyc;
        sb.push_back(e);
        sent++;
        if (sent < NOPS) begin
          ra = W'($urandom);
          rb = W'($urandom);
          if (sent % 5 == 0) rb = ra;
          if (sent % 7 == 3) begin
            ra = W'($urandom_range(0, 300));
            rb = W'($urandom_range(0, 300));
          end
          a = ra;
          b = rb;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    if (got < NOPS) chk("b2b_timeout", got, NOPS);
    out_ready = 1'b0;
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
